division_saturada: RTL
======================

# division_saturada

Multi-cycle signed fixed-point divider with saturation for the arithmetic unit. It performs the inverse of the unit's multiply path and uses the same number format and saturation rules as the saturating adder. Operands and result are N-bit two's complement with F fractional bits. The result is Q = (A·2^F)/B, truncated toward zero and clamped to the representable range. One restoring-division iteration runs per clock; a start/ready/done handshake sequences the operation for the FSM that drives the arithmetic unit.

## Interface
- N, default 25: total word width (sign included), two's complement.
- F, default 10: fractional bits of A, B and COC (Q(N-F).F format).
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset (sampled on rising edge of clk).
- start  input  1  request; sampled only while ready=1.
- A  input  N  dividend, signed fixed-point; captured at the accepting edge.
- B  input  N  divisor, signed fixed-point; captured at the accepting edge.
- ready  output  1  1 when idle and able to accept start.
- done  output  1  single-cycle pulse: COC and div_cero are valid and new.
- COC  output  N  quotient, signed fixed-point, saturated; held until next done.
- div_cero  output  1  1 if the last completed operation had B=0; updated with done.

## Operation
- States:
  - IDLE: ready=1.
  - CALC: iterating.
  - FIN: registers the result.
- Transitions:
  - IDLE→CALC on start=1. At this edge, capture:
    - sign_q = A[N-1] XOR B[N-1];
    - |A| and |B| as N-bit unsigned (|−2^(N-1)| = 2^(N-1) fits unsigned);
    - the dividend register = |A|<<F, width N+F;
    - the remainder register cleared, width N+1;
    - the iteration counter loaded with N+F.
  - CALC: each edge shifts in one dividend bit MSB-first and trial-subtracts |B|. If the remainder is ≥ |B|, it subtracts and the quotient bit is 1; otherwise the quotient bit is 0. The counter decrements. After N+F iterations → FIN.
  - FIN→IDLE unconditionally. At this edge, COC and div_cero are registered and done is asserted for exactly one cycle.
- Result rules (quotient magnitude q, N+F bits unsigned):
  - B=0: COC = 2^(N-1)-1 if A≥0, else −2^(N-1); div_cero=1. Iterations still run, so latency is fixed.
  - sign_q=0 and q > 2^(N-1)-1: COC = 2^(N-1)-1.
  - sign_q=1 and q > 2^(N-1): COC = −2^(N-1).
  - otherwise COC = sign_q ? −q : q (N-bit); div_cero=0.
  - A=0 with B≠0 gives COC=0 regardless of the sign of B.
- start while ready=0 is ignored: no queuing, operands not recaptured.
- A and B may change freely after the accepting edge.

## Timing
- Reset values: ready=1, done=0, COC=0, div_cero=0, state IDLE, counter 0.
- Latency: accepting edge = edge 0; iterations occur on edges 1..N+F; edge N+F+1 registers COC and sets done=1. The done cycle is visible after edge N+F+1 (36 cycles at the defaults).
- ready falls after edge 0 and rises after edge N+F+1, concurrent with done=1. start may be asserted in the done cycle and is accepted at the next edge, giving back-to-back throughput of one result per N+F+2 cycles.
- Reset mid-operation (any state) → all outputs return to their reset values on that edge; the operation in flight is discarded and no done is issued.
- reset and start both high on the same edge: reset wins.

## Test plan
- Basic: N=25, F=10; A=3072 (3.0), B=2048 (2.0), start one cycle → after 36 cycles done=1 for one cycle, COC=1536 (1.5), div_cero=0.
- Signs and truncation:
  - A=−7168, B=2048 → COC=−3584.
  - A=1024, B=3072 → COC=341.
  - A=−1024, B=3072 → COC=−341 (truncation toward zero).
- Saturation:
  - A=16777215, B=1 → COC=16777215.
  - A=−16777216, B=1 → COC=−16777216.
  - A=−16777216, B=−1024 → COC=16777215 (positive overflow).
- Division by zero:
  - A=5, B=0 → COC=16777215, div_cero=1.
  - A=−5, B=0 → COC=−16777216, div_cero=1.
  - Next op A=2048, B=1024 → COC=2048, div_cero=0.
- Handshake:
  - start held high for 40 cycles → exactly two done pulses, 37 cycles apart.
  - A/B changed at cycle 5 → result uses the operands captured at edge 0.
- Reset: assert reset at cycle 10 of an operation → ready=1, COC=0, no done; a new start then completes normally in 36 cycles.

Source files
------------

// File: rtl/division_saturada.sv
// ---------------------------------------------------------------------------
// division_saturada
//
// Multi-cycle signed fixed-point divider with saturation.
// It computes Q = (A * 2^F) / B, truncates toward zero and clamps the result
// to the N-bit two's complement range. It uses one restoring-division
// iteration per clock.
//
// Ports
//   clk       system clock, all state changes on the rising edge
//   reset     synchronous, active-high reset
//   start     operation request, only honoured while ready=1
//   A, B      dividend / divisor, signed Q(N-F).F, captured when accepted
//   ready     high while idle and able to accept start
//   done      one-cycle pulse when COC / div_cero carry a new result
//   COC       saturated signed quotient, held until the next done
//   div_cero  high if the last completed operation divided by zero
// ---------------------------------------------------------------------------
module division_saturada #(
    parameter int N = 25,
    parameter int F = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] COC,
    output logic         div_cero
);

    localparam int W  = N + F;
    localparam int CW = $clog2(W + 1);

    localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};
    // Largest quotient magnitudes that still fit, expressed at quotient width.
    localparam logic [W-1:0] LIM_POS = W'((64'd1 << (N-1)) - 64'd1);
    localparam logic [W-1:0] LIM_NEG = W'(64'd1 << (N-1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t         state_reg,    state_next;
    logic [CW-1:0]  count_reg,    count_next;
    logic [W-1:0]   dividend_reg, dividend_next;
    logic [N:0]     rem_reg,      rem_next;
    logic [W-1:0]   quot_reg,     quot_next;
    logic [N-1:0]   mag_b_reg,    mag_b_next;
    logic           sign_q_reg,   sign_q_next;
    logic           a_neg_reg,    a_neg_next;
    logic           b_zero_reg,   b_zero_next;
    logic [N-1:0]   coc_reg,      coc_next;
    logic           div_cero_reg, div_cero_next;
    logic           done_reg,     done_next;

    logic [N-1:0]   abs_a;
    logic [N-1:0]   abs_b;
    logic [N+1:0]   rem_shift;
    logic [N+1:0]   rem_trial;
    logic           fits;
    logic [N-1:0]   sat_value;

    // |x| as unsigned; the most negative value maps to 2^(N-1), which fits.
    assign abs_a = A[N-1] ? (N'(0) - A) : A;
    assign abs_b = B[N-1] ? (N'(0) - B) : B;

    // One extra top bit so the sign of the trial difference is the borrow.
    assign rem_shift = {rem_reg, dividend_reg[W-1]};
    assign rem_trial = rem_shift - {2'b00, mag_b_reg};
    assign fits      = ~rem_trial[N+1];

    // Saturation of the finished quotient magnitude.
    always_comb begin
        sat_value = '0;
        if (b_zero_reg) begin
            sat_value = a_neg_reg ? MIN_NEG : MAX_POS;
        end else if (!sign_q_reg && (quot_reg > LIM_POS)) begin
            sat_value = MAX_POS;
        end else if (sign_q_reg && (quot_reg > LIM_NEG)) begin
            sat_value = MIN_NEG;
        end else if (sign_q_reg) begin
            sat_value = N'(0) - quot_reg[N-1:0];
        end else begin
            sat_value = quot_reg[N-1:0];
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        dividend_next = dividend_reg;
        rem_next      = rem_reg;
        quot_next     = quot_reg;
        mag_b_next    = mag_b_reg;
        sign_q_next   = sign_q_reg;
        a_neg_next    = a_neg_reg;
        b_zero_next   = b_zero_reg;
        coc_next      = coc_reg;
        div_cero_next = div_cero_reg;
        done_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next    = CALC;
                    sign_q_next   = A[N-1] ^ B[N-1];
                    a_neg_next    = A[N-1];
                    b_zero_next   = (B == '0);
                    mag_b_next    = abs_b;
                    dividend_next = {abs_a, {F{1'b0}}};
                    rem_next      = '0;
                    quot_next     = '0;
                    count_next    = CW'(W);
                end
            end
            CALC: begin
                // B=0 simply yields all-ones here; the flag overrides it later.
                dividend_next = dividend_reg << 1;
                rem_next      = fits ? rem_trial[N:0] : rem_shift[N:0];
                quot_next     = {quot_reg[W-2:0], fits};
                count_next    = count_reg - CW'(1);
                if (count_reg == CW'(1)) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next    = IDLE;
                coc_next      = sat_value;
                div_cero_next = b_zero_reg;
                done_next     = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            dividend_reg <= '0;
            rem_reg      <= '0;
            quot_reg     <= '0;
            mag_b_reg    <= '0;
            sign_q_reg   <= 1'b0;
            a_neg_reg    <= 1'b0;
            b_zero_reg   <= 1'b0;
            coc_reg      <= '0;
            div_cero_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            dividend_reg <= dividend_next;
            rem_reg      <= rem_next;
            quot_reg     <= quot_next;
            mag_b_reg    <= mag_b_next;
            sign_q_reg   <= sign_q_next;
            a_neg_reg    <= a_neg_next;
            b_zero_reg   <= b_zero_next;
            coc_reg      <= coc_next;
            div_cero_reg <= div_cero_next;
            done_reg     <= done_next;
        end
    end

    assign ready    = (state_reg == IDLE);
    assign done     = done_reg;
    assign COC      = coc_reg;
    assign div_cero = div_cero_reg;

endmodule
